// File: rtl/score_bcd_counter.sv
// score_bcd_counter: BCD score accumulator with a digit-serial ripple add and an atomic commit.
// Optional feature macro: SCORE_OVER_TEXT_EN. When it is defined, the outputs show the "OVER" glyph codes while game_over is high.
module score_bcd_counter #(
    parameter logic [3:0] PTS_1 = 4'd1,
    parameter logic [3:0] PTS_2 = 4'd3,
    parameter logic [3:0] PTS_3 = 4'd5,
    parameter logic [3:0] PTS_4 = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add_valid,
    input  logic [2:0] add_lines,
    output logic       add_ready,
    input  logic       clear,
    input  logic       game_over,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic [3:0] score_3,
    output logic [3:0] score_4,
    output logic       busy,
    output logic       saturated
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADD0   = 3'd1;
    localparam logic [2:0] COMMIT = 3'd5;

    logic [2:0] state;
    logic [3:0] score [4];
    logic [3:0] work [4];
    logic [3:0] addend, pts, digit;
    logic [1:0] idx;
    logic [4:0] sum;
    logic       carry;

    assign add_ready = (state == IDLE) && !game_over && !clear;
    assign busy      = state != IDLE;

    // Map lines cleared to points, then form one digit of the ripple sum for the current ADD state.
    always_comb begin
        pts   = add_lines == 3'd1 ? PTS_1 :
                add_lines == 3'd2 ? PTS_2 :
                add_lines == 3'd3 ? PTS_3 :
                add_lines == 3'd4 ? PTS_4 : 4'd0;
        idx   = state[1:0] - 2'd1;
        sum   = {1'b0, score[idx]} + {1'b0, idx == 2'd0 ? addend : 4'd0} + {4'd0, carry};
        digit = sum > 5'd9 ? sum[3:0] - 4'd10 : sum[3:0];
    end

    // Sequencer: accept, ripple one digit per clock into work, then commit, or clip to 9999 on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            state     <= IDLE;
            addend    <= 4'd0;
            carry     <= 1'b0;
            saturated <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                score[i] <= 4'd0;
                work[i]  <= 4'd0;
            end
        end else if (state == IDLE) begin
            if (add_valid && add_ready) begin
                state  <= ADD0;
                addend <= pts;
                carry  <= 1'b0;
            end
        end else if (state == COMMIT) begin
            for (int i = 0; i < 4; i++)
                score[i] <= carry ? 4'd9 : work[i];
            saturated <= saturated | carry;
            state     <= IDLE;
        end else begin
            work[idx] <= digit;
            carry     <= sum > 5'd9;
            state     <= state + 3'd1;
        end
    end

`ifdef SCORE_OVER_TEXT_EN
    assign score_4 = game_over ? 4'd12 : score[3];
    assign score_3 = game_over ? 4'd13 : score[2];
    assign score_2 = game_over ? 4'd14 : score[1];
    assign score_1 = game_over ? 4'd15 : score[0];
`else
    assign score_4 = score[3];
    assign score_3 = score[2];
    assign score_2 = score[1];
    assign score_1 = score[0];
`endif
endmodule

// File: tb/tb_score_bcd_counter.sv
// tb_score_bcd_counter: randomized check of score_bcd_counter against an integer score model.
module tb_score_bcd_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       add_valid = 1'b0;
    logic [2:0] add_lines = 3'd0;
    logic       clear = 1'b0;
    logic       game_over = 1'b0;
    logic       add_ready, busy, saturated;
    logic [3:0] score_1, score_2, score_3, score_4;

    int checks = 0;
    int errors = 0;
    int m_score = 0;
    int m_pend = 0;
    int m_cnt = 0;
    bit m_sat = 1'b0;

    score_bcd_counter dut (
        .clk(clk), .rst(rst), .add_valid(add_valid), .add_lines(add_lines),
        .add_ready(add_ready), .clear(clear), .game_over(game_over),
        .score_1(score_1), .score_2(score_2), .score_3(score_3), .score_4(score_4),
        .busy(busy), .saturated(saturated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h score=%0d t=%0t", tag, got, exp, m_score, $time);
        end
    endtask

    function automatic int points(input logic [2:0] l);
        return l == 3'd1 ? 1 : l == 3'd2 ? 3 : l == 3'd3 ? 5 : l == 3'd4 ? 8 : 0;
    endfunction

    function automatic logic [15:0] expect_disp();
        logic [15:0] d;
        d = {4'(m_score / 1000), 4'((m_score / 100) % 10), 4'((m_score / 10) % 10), 4'(m_score % 10)};
`ifdef SCORE_OVER_TEXT_EN
        if (game_over) d = 16'hCDEF;
`endif
        return d;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".disp"}, {score_4, score_3, score_2, score_1}, expect_disp());
        check({tag, ".busy"}, 16'(busy), 16'(m_cnt > 0));
        check({tag, ".sat"}, 16'(saturated), 16'(m_sat));
        check({tag, ".ready"}, 16'(add_ready), 16'(m_cnt == 0 && !game_over && !clear));
    endtask

    // Called at a negedge: apply inputs, take the edge, update the model, check at the next negedge.
    task automatic step(input logic v, input logic [2:0] l, input logic c, input logic g, input string tag);
        add_valid = v; add_lines = l; clear = c; game_over = g;
        @(posedge clk);
        if (c) begin
            m_score = 0; m_sat = 1'b0; m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                if (m_pend > 9999) begin
                    m_score = 9999; m_sat = 1'b1;
                end else m_score = m_pend;
            end
        end else if (v && !g) begin
            m_cnt = 5;
            m_pend = m_score + points(l);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        add_valid = 1'b0; clear = 1'b0; game_over = 1'b0;
        #2 rst = 1'b1;
        m_score = 0; m_sat = 1'b0; m_cnt = 0;
        #1 check_all(tag);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic g;
        g = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");
        step(1, 3'd4, 0, 0, "add8");
        repeat (5) step(0, 3'd0, 0, 0, "add8_wait");
        step(1, 3'd2, 0, 0, "add3");
        repeat (5) step(0, 3'd0, 0, 0, "add3_wait");
        step(1, 3'd1, 0, 0, "clr_acc");
        step(0, 3'd0, 0, 0, "clr_add0");
        step(0, 3'd0, 1, 0, "clr_add1");
        repeat (6) step(0, 3'd0, 0, 0, "clr_after");
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) g = ~g;
            step($urandom_range(0, 1), 3'($urandom), $urandom_range(0, 49) == 0, g, "rand");
        end
        step(0, 3'd0, 1, 0, "clr_pre_sat");
        repeat (9000) step(1, 3'($urandom_range(3, 4)), 0, $urandom_range(0, 29) == 0, "fill");
        repeat (40) step($urandom_range(0, 1), 3'($urandom), 0, $urandom_range(0, 3) == 0, "sat_hold");
        step(0, 3'd0, 1, 0, "clr_sat");
        repeat (6) step(1, 3'($urandom), 0, 0, "after_clr");
        repeat (2) step(0, 3'd0, 0, 0, "pre_rst");
        step(1, 3'd4, 0, 0, "rst_acc");
        step(0, 3'd0, 0, 0, "rst_add0");
        async_reset("async_rst");
        repeat (1500) begin
            if ($urandom_range(0, 29) == 0) g = ~g;
            step($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 99) == 0, g, "rand2");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
